vdp_screen_position_counter: RTL
================================

Name: vdp_screen_position_counter

Overview:
Master raster counter of the VDP, running on the 42.95454 MHz clock. It generates screen_pos_x, pixel_pos_y and screen_active, which feed the per-mode timing-control stages (the G4–G7 bitmap fetch and the other modes) directly. It also produces composite sync timing and the frame/line interrupt pulses. Frame geometry (50/60 Hz, 192/212 lines) and vertical scroll come from VDP registers.

Parameters:
H_TOTAL, 2736, clocks per line (h_cnt 0..H_TOTAL-1)
X_OFFSET, 128, h_cnt value at which screen_pos_x = 0
H_SYNC_START, 2400, h_cnt at which h_sync asserts
H_SYNC_WIDTH, 200, h_sync length in clocks

Ports:
clk  in  1  42.95454 MHz system clock
reset_n  in  1  synchronous active-low reset
reg_50hz  in  1  0: NTSC 262 lines, 1: PAL 313 lines
reg_212lines  in  1  0: 192 active lines, 1: 212 active lines
reg_vertical_offset  in  8  vertical scroll (R#23), added to pixel_pos_y
reg_interrupt_line  in  8  line interrupt compare value (R#19)
screen_pos_x  out  13  signed, h_cnt - X_OFFSET, two's complement
pixel_pos_y  out  8  (v_cnt + latched offset) mod 256
screen_active  out  1  current line is an active display line
h_sync  out  1  active-high horizontal sync
v_sync  out  1  active-high vertical sync
intr_frame  out  1  one-clock pulse at start of vertical blank
intr_line  out  1  one-clock pulse at end of the matching active line

Behaviour:
- Internal h_cnt (12 bit) and v_cnt (9 bit). h_cnt increments every clock and wraps H_TOTAL-1 -> 0; v_cnt increments on h_cnt wrap and wraps V_TOTAL-1 -> 0.
- V_TOTAL = 313 if latched 50 Hz, else 262. N_ACT = 212 if latched 212-line, else 192.
- reg_50hz and reg_212lines are latched only on frame wrap (h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1). Mid-frame changes never alter the current frame.
- reg_vertical_offset is latched at every line wrap.
- All outputs are registered and coherent with h_cnt/v_cnt in the same cycle.
- screen_pos_x = h_cnt - X_OFFSET, 13-bit wrap. With defaults it runs 13'h1F80 (-128) .. 2607, incrementing by 1 per clock.
- Active pixel area is screen_pos_x 0..2047.
- screen_active and pixel_pos_y change only at line start (h_cnt = 0) and are constant for the whole line:
  - screen_active = (v_cnt < N_ACT).
  - pixel_pos_y = (v_cnt + offset)[7:0].
- h_sync = 1 while H_SYNC_START <= h_cnt < H_SYNC_START + H_SYNC_WIDTH.
- v_sync = 1 for lines V_TOTAL-22 .. V_TOTAL-20 (NTSC 240..242, PAL 291..293). Changes only at h_cnt = 0.
- intr_frame = 1 for exactly one clock when h_cnt = 0 and v_cnt = N_ACT.
- intr_line = 1 for exactly one clock when h_cnt = X_OFFSET + 2048 (2176), screen_active = 1 and pixel_pos_y == reg_interrupt_line.
  - reg_interrupt_line is compared live, not latched.
- Reset state (held while reset_n = 0; sampled reset takes effect on the next edge):
  - h_cnt 0, v_cnt 261; latched 50 Hz = 0, latched 212-line = 0, latched offset 0.
  - screen_pos_x 13'h1F80, pixel_pos_y 8'd5, screen_active 0.
  - h_sync 0, v_sync 0, intr_frame 0, intr_line 0.
  - The first line after reset is therefore the last blanking line. Line 0 of frame 1 starts H_TOTAL clocks after reset release.
- Reset asserted mid-frame returns to the reset state on the next edge. No pulse is emitted during reset.

Optional Feature:
VDP_INTERLACE_EN.
- Defined: adds input reg_interlace (1) and output field_odd (1).
  - field_odd toggles on each frame wrap; reset 0.
  - With reg_interlace = 1, odd fields use V_TOTAL + 1 lines (263 NTSC / 314 PAL), and v_sync is delayed by half a line (asserts at h_cnt = H_TOTAL/2).
  - With reg_interlace = 0, behaviour is identical to the non-interlace build except that field_odd still toggles.
- Undefined: neither port exists; V_TOTAL is fixed at 262/313.

Test Plan:
- Reset release, defaults -> screen_pos_x = 13'h1F80 on the first cycle, counts to 2607 then wraps to 13'h1F80. Exactly 2736 clocks later: screen_active = 1, pixel_pos_y = 0.
- NTSC/192 free run -> intr_frame period 716832 clocks. screen_active high for 192 consecutive lines per frame. v_sync high for 3 lines (3 × 2736 clocks).
- Set reg_50hz = 1, reg_212lines = 1 at line 100 -> current frame keeps 262/192. Next frame has 212 active lines and intr_frame period 856368.
- reg_vertical_offset = 8'hF8 -> pixel_pos_y on line 0 is 248, line 8 is 0. Value is constant within each line.
- reg_interrupt_line = 100, offset 0 -> exactly one intr_line pulse per frame, at h_cnt 2176 of v_cnt 100. With the value 200 in 192-line mode -> no pulse.
- reset_n low for 3 clocks mid-line at v_cnt 50 -> reset values reproduced and no intr pulses. Timing then restarts exactly as in the first scenario.

Source files
------------

// File: rtl/vdp_screen_position_counter.sv
// vdp_screen_position_counter: master raster counter of the VDP.
// Generates screen_pos_x / pixel_pos_y / screen_active for the mode timing stages,
// composite sync timing, and the frame / line interrupt pulses.
// Optional build macro VDP_INTERLACE_EN adds reg_interlace input and field_odd output.
// Every output is registered from next-state counter values, so each output is
// coherent with h_cnt/v_cnt in the same cycle.
module vdp_screen_position_counter #(
    parameter int unsigned H_TOTAL      = 2736,
    parameter int unsigned X_OFFSET     = 128,
    parameter int unsigned H_SYNC_START = 2400,
    parameter int unsigned H_SYNC_WIDTH = 200,
    parameter int unsigned ACTIVE_WIDTH = 2048
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_50hz,
    input  logic        reg_212lines,
    input  logic [7:0]  reg_vertical_offset,
    input  logic [7:0]  reg_interrupt_line,
`ifdef VDP_INTERLACE_EN
    input  logic        reg_interlace,
    output logic        field_odd,
`endif
    output logic [12:0] screen_pos_x,
    output logic [7:0]  pixel_pos_y,
    output logic        screen_active,
    output logic        h_sync,
    output logic        v_sync,
    output logic        intr_frame,
    output logic        intr_line
);

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_SYNC_ON  = 12'(H_SYNC_START);
    localparam logic [11:0] H_SYNC_OFF = 12'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [11:0] H_INTR     = 12'(X_OFFSET + ACTIVE_WIDTH);
    localparam logic [12:0] X_OFS      = 13'(X_OFFSET);
    localparam logic [8:0]  V_RESET    = 9'd261;
`ifdef VDP_INTERLACE_EN
    localparam logic [11:0] H_HALF     = 12'(H_TOTAL / 2);
`endif

    logic [11:0] r_h_cnt;
    logic [8:0]  r_v_cnt;
    logic        r_pal;
    logic        r_212;
    logic [7:0]  r_offset;
    logic [12:0] r_screen_pos_x;
    logic [7:0]  r_pixel_pos_y;
    logic        r_screen_active;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_intr_frame;
    logic        r_intr_line;
`ifdef VDP_INTERLACE_EN
    logic        r_interlace;
    logic        r_field_odd;
    logic        w_il_next;
    logic        w_odd_next;
`endif

    logic        w_line_wrap;
    logic        w_frame_wrap;
    logic [8:0]  w_v_last;
    logic [11:0] w_h_next;
    logic [8:0]  w_v_next;
    logic        w_pal_next;
    logic        w_212_next;
    logic [7:0]  w_offset_next;
    logic        w_long_next;
    logic        w_vs_update;
    logic [8:0]  w_n_act_next;
    logic [8:0]  w_v_total_next;
    logic        w_in_vsync;

    // Next-state counters and the frame geometry that applies to the next cycle
    always_comb begin
        w_line_wrap = (r_h_cnt == H_LAST);
`ifdef VDP_INTERLACE_EN
        w_v_last = (r_pal ? 9'd312 : 9'd261) + {8'd0, (r_interlace & r_field_odd)};
`else
        w_v_last = r_pal ? 9'd312 : 9'd261;
`endif
        w_frame_wrap = w_line_wrap && (r_v_cnt == w_v_last);
        w_h_next     = w_line_wrap ? 12'd0 : r_h_cnt + 12'd1;
        if (w_frame_wrap) begin
            w_v_next = 9'd0;
        end else if (w_line_wrap) begin
            w_v_next = r_v_cnt + 9'd1;
        end else begin
            w_v_next = r_v_cnt;
        end
        // Geometry registers only move at frame wrap, offset at every line wrap
        w_pal_next    = w_frame_wrap ? reg_50hz : r_pal;
        w_212_next    = w_frame_wrap ? reg_212lines : r_212;
        w_offset_next = w_line_wrap ? reg_vertical_offset : r_offset;
`ifdef VDP_INTERLACE_EN
        w_il_next   = w_frame_wrap ? reg_interlace : r_interlace;
        w_odd_next  = w_frame_wrap ? ~r_field_odd : r_field_odd;
        w_long_next = w_il_next & w_odd_next;
        // Long (odd interlaced) fields move v_sync by half a line
        w_vs_update = w_long_next ? (w_h_next == H_HALF) : w_line_wrap;
`else
        w_long_next = 1'b0;
        w_vs_update = w_line_wrap;
`endif
        w_n_act_next   = w_212_next ? 9'd212 : 9'd192;
        w_v_total_next = (w_pal_next ? 9'd313 : 9'd262) + {8'd0, w_long_next};
        w_in_vsync     = (w_v_next >= w_v_total_next - 9'd22) &&
                         (w_v_next <= w_v_total_next - 9'd20);
    end

    // Raster counters and latched frame/line configuration
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_h_cnt     <= 12'd0;
            r_v_cnt     <= V_RESET;
            r_pal       <= 1'b0;
            r_212       <= 1'b0;
            r_offset    <= 8'd0;
`ifdef VDP_INTERLACE_EN
            r_interlace <= 1'b0;
            r_field_odd <= 1'b0;
`endif
        end else begin
            r_h_cnt     <= w_h_next;
            r_v_cnt     <= w_v_next;
            r_pal       <= w_pal_next;
            r_212       <= w_212_next;
            r_offset    <= w_offset_next;
`ifdef VDP_INTERLACE_EN
            r_interlace <= w_il_next;
            r_field_odd <= w_odd_next;
`endif
        end
    end

    // Registered outputs derived from the next-state counter values
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_screen_pos_x  <= 13'h1F80 + (13'd128 - X_OFS);
            r_pixel_pos_y   <= V_RESET[7:0];
            r_screen_active <= 1'b0;
            r_h_sync        <= 1'b0;
            r_v_sync        <= 1'b0;
            r_intr_frame    <= 1'b0;
            r_intr_line     <= 1'b0;
        end else begin
            r_screen_pos_x <= {1'b0, w_h_next} - X_OFS;
            if (w_line_wrap) begin
                r_screen_active <= (w_v_next < w_n_act_next);
                r_pixel_pos_y   <= w_v_next[7:0] + w_offset_next;
            end
            if (w_vs_update) begin
                r_v_sync <= w_in_vsync;
            end
            r_h_sync     <= (w_h_next >= H_SYNC_ON) && (w_h_next < H_SYNC_OFF);
            r_intr_frame <= w_line_wrap && (w_v_next == w_n_act_next);
            // Line state is stable mid-line, so the current registers describe h_next too
            r_intr_line  <= (w_h_next == H_INTR) && r_screen_active &&
                            (r_pixel_pos_y == reg_interrupt_line);
        end
    end

    assign screen_pos_x  = r_screen_pos_x;
    assign pixel_pos_y   = r_pixel_pos_y;
    assign screen_active = r_screen_active;
    assign h_sync        = r_h_sync;
    assign v_sync        = r_v_sync;
    assign intr_frame    = r_intr_frame;
    assign intr_line     = r_intr_line;
`ifdef VDP_INTERLACE_EN
    assign field_odd     = r_field_odd;
`endif

endmodule
